irq_pending_ctrl: RTL and testbench

Interrupt request front-end that latches up to 8 request lines into a pending register, applies per-line masking and edge/level selection, and offers the highest-numbered pending, enabled request to the consumer over a valid/ready handshake. It sits directly upstream of the 8-to-3 priority-encode/dispatch path. It also tracks the in-service interrupt until the consumer signals end-of-interrupt (EOI).

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_pending_ctrl_if.sv | 35 +++
 rtl/irq_pri_select.sv | 24 ++
 rtl/irq_pending_ctrl.sv | 92 +++++++++
 tb/tb_irq_pending_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending controller.
//   N_REQ : number of request lines (fixed at 8)
//   ID_W  : width of a request index
//   irq_state_e : controller state (IDLE, OFFER, SERVICE)
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Bundle of request, configuration and handshake signals around the
// interrupt pending controller.
//   master : the controller side (consumes requests/config, offers irq_id)
//   slave  : the environment side (request lines, consumer handshake, EOI)
// Signals:
//   req_in, edge_sel, mask : request lines and per-line trigger/enable config
//   irq_valid, irq_id      : current offer
//   irq_ready              : consumer accepts the offer
//   eoi                    : end of interrupt for the in-service request
//   busy                   : an interrupt is in service
//   pending_out            : the pending register
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] edge_sel;
  logic [N_REQ-1:0] mask;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic             irq_ready;
  logic             eoi;
  logic             busy;
  logic [N_REQ-1:0] pending_out;

  modport master (
    input  req_in, edge_sel, mask, irq_ready, eoi,
    output irq_valid, irq_id, busy, pending_out
  );

  modport slave (
    output req_in, edge_sel, mask, irq_ready, eoi,
    input  irq_valid, irq_id, busy, pending_out
  );

endinterface

// File: rtl/irq_pri_select.sv
// Combinational highest-index-wins selector.
//   vec : request vector
//   idx : index of the highest set bit (0 when vec is all zero)
//   any : at least one bit of vec is set
module irq_pri_select
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one.
  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    idx = '0;
    any = |vec;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt request front-end: latches edge/level requests into a pending
// register, offers the highest-numbered enabled pending request over a
// valid/ready handshake and tracks it in service until EOI.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : irq_pending_ctrl_if.master (requests, config, handshake, status)
module irq_pending_ctrl
  import irq_pkg::*;
(
  input logic               clk,
  input logic               rst,
  irq_pending_ctrl_if.master bus
);

  irq_state_e       state_q, state_d;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] set_vec;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] candidate;
  logic [ID_W-1:0]  sel_id;
  logic             sel_any;
  logic             accept;

  assign candidate = pending_q & bus.mask;

  irq_pri_select u_pri_select (
    .vec (candidate),
    .idx (sel_id),
    .any (sel_any)
  );

  always_comb begin
    // Edge lines fire on a 0->1 transition, level lines whenever high.
    set_vec = (bus.edge_sel & bus.req_in & ~req_q) | (~bus.edge_sel & bus.req_in);
    accept  = (state_q == OFFER) && bus.irq_ready;
    clr_vec = '0;
    if (accept) clr_vec[id_q] = 1'b1;
    // Set is applied after clear so a new edge on the accepted line survives.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          id_d    = sel_id;
          state_d = OFFER;
        end
      end
      // irq_id is frozen here: no retraction on mask/pending changes.
      OFFER:   if (bus.irq_ready) state_d = SERVICE;
      SERVICE: if (bus.eoi)       state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered decodes of the next state.
    valid_d = (state_d == OFFER);
    busy_d  = (state_d == SERVICE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      state_q   <= state_d;
      req_q     <= bus.req_in;
      pending_q <= pending_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.irq_valid   = valid_q;
  assign bus.irq_id      = id_q;
  assign bus.busy        = busy_q;
  assign bus.pending_out = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of pending lines and the offer/service lifecycle.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing outstanding, 1 = request offered, 2 = in service
  bit m_pend [8];
  bit m_prev [8];
  int m_phase;
  int m_id;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_phase = 0;
      m_id    = 0;
    end else begin
      if (m_phase == 0) begin
        for (int i = 7; i >= 0; i--) begin
          if (m_pend[i] && bus.mask[i]) begin
            m_id    = i;
            m_phase = 1;
            break;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.irq_ready) begin
          m_pend[m_id] = 1'b0;
          m_phase      = 2;
        end
      end else begin
        if (bus.eoi) m_phase = 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (bus.edge_sel[i] ? (bus.req_in[i] && !m_prev[i]) : bus.req_in[i])
          m_pend[i] = 1'b1;
        m_prev[i] = bus.req_in[i];
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_p;
    for (int i = 0; i < 8; i++) exp_p[i] = m_pend[i];
    check("model_irq_valid", 32'(bus.irq_valid), 32'(m_phase == 1));
    check("model_busy", 32'(bus.busy), 32'(m_phase == 2));
    check("model_irq_id", 32'(bus.irq_id), 32'(m_id));
    check("model_pending", 32'(bus.pending_out), 32'(exp_p));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req_in   = '0;
    bus.edge_sel = 8'hFF;
    bus.mask     = 8'hFF;
    bus.irq_ready = 1'b0;
    bus.eoi      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_offer(input string name, input int exp_id, input int budget);
    int n;
    n = 0;
    while (!bus.irq_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 32'(bus.irq_valid), 32'd1);
    check({name, "_id"}, 32'(bus.irq_id), 32'(exp_id));
  endtask

  task automatic accept_eoi();
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    check("idle_after_eoi", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with all lines high, level mode.
    rst           = 1'b1;
    bus.req_in    = 8'hFF;
    bus.edge_sel  = 8'h00;
    bus.mask      = 8'hFF;
    bus.irq_ready = 1'b0;
    bus.eoi       = 1'b0;
    tick(); tick(); tick();
    check("rst_valid", 32'(bus.irq_valid), 32'd0);
    check("rst_id", 32'(bus.irq_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pending", 32'(bus.pending_out), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_pending", 32'(bus.pending_out), 32'hFF);
    check("rel_valid_early", 32'(bus.irq_valid), 32'd0);
    tick();
    check("rel_valid", 32'(bus.irq_valid), 32'd1);
    check("rel_id", 32'(bus.irq_id), 32'd7);

    // Priority: ids 5 then 2.
    do_reset();
    bus.req_in = 8'b0010_0100;
    tick();
    bus.req_in = 8'h00;
    tick();
    check("prio_first_valid", 32'(bus.irq_valid), 32'd1);
    check("prio_first_id", 32'(bus.irq_id), 32'd5);
    accept_eoi();
    wait_offer("prio_second", 2, 4);
    accept_eoi();
    tick();
    check("prio_done_pending", 32'(bus.pending_out), 32'd0);
    check("prio_done_valid", 32'(bus.irq_valid), 32'd0);

    // Handshake hold while bit 6 pulses.
    do_reset();
    bus.req_in = 8'h08;
    tick();
    bus.req_in = 8'h00;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.req_in = (i % 2 == 0) ? 8'h40 : 8'h00;
      tick();
      check("hold_valid", 32'(bus.irq_valid), 32'd1);
      check("hold_id", 32'(bus.irq_id), 32'd3);
    end
    bus.req_in = 8'h00;
    accept_eoi();
    wait_offer("hold_next", 6, 4);
    accept_eoi();

    // Masked pending retained, offered once unmasked.
    do_reset();
    bus.mask   = 8'hEF;
    bus.req_in = 8'h10;
    tick();
    bus.req_in = 8'h00;
    tick();
    tick();
    check("mask_pending", 32'(bus.pending_out), 32'h10);
    check("mask_no_offer", 32'(bus.irq_valid), 32'd0);
    bus.mask = 8'hFF;
    wait_offer("mask_offer", 4, 3);
    accept_eoi();

    // Set/clear collision on bit 1.
    do_reset();
    bus.req_in = 8'h02;
    tick();
    bus.req_in = 8'h00;
    tick();
    check("coll_id", 32'(bus.irq_id), 32'd1);
    bus.irq_ready = 1'b1;
    bus.req_in    = 8'h02;
    tick();
    bus.irq_ready = 1'b0;
    bus.req_in    = 8'h00;
    check("coll_pending1", 32'(bus.pending_out[1]), 32'd1);
    check("coll_busy", 32'(bus.busy), 32'd1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    wait_offer("coll_reoffer", 1, 3);
    accept_eoi();

    // Reset in the middle of service.
    do_reset();
    bus.req_in = 8'h01;
    tick();
    bus.req_in = 8'h00;
    tick();
    bus.irq_ready = 1'b1;
    tick();
    bus.irq_ready = 1'b0;
    bus.req_in    = 8'h20;
    tick();
    bus.req_in = 8'h00;
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    check("mid_pending_before", 32'(bus.pending_out), 32'h20);
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_valid", 32'(bus.irq_valid), 32'd0);
    check("mid_pending", 32'(bus.pending_out), 32'd0);
    tick();
    rst     = 1'b0;
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    tick();
    check("stray_eoi_valid", 32'(bus.irq_valid), 32'd0);
    check("stray_eoi_busy", 32'(bus.busy), 32'd0);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      bus.req_in = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      if (c % 64 == 0) bus.edge_sel = 8'($urandom_range(0, 255));
      if (c % 16 == 0) bus.mask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      bus.irq_ready = ($urandom_range(0, 3) == 0);
      bus.eoi       = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
